// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - registered N-source bus arbiter, fixed priority or round-robin, with lock
// Optional conflict counter enabled by macro BUS_ARBITER_CONFLICT_CNT_EN.
module bus_arbiter #(
    parameter int N_SRC = 7,
    parameter int SEL_W = 3,
    parameter int RR    = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic             lock,
    input  logic             cnt_clr,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Width of a source index; the RR pointer holds the last granted index.
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             conflict_q, conflict_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] start_idx;
    logic [N_SRC-1:0] req_hi;
    logic             found_hi, found_any;
    logic [IDX_W-1:0] idx_hi, idx_any, win_idx;
    logic             held;

    // Search start: one below the last grant for round-robin, top index for fixed priority.
    // Pointer 0 (its reset value) wraps the start to N_SRC-1, matching fixed priority.
    always_comb begin
        start_idx = IDX_W'(N_SRC - 1);
        if (RR != 0) begin
            if (ptr_q == '0) begin
                start_idx = IDX_W'(N_SRC - 1);
            end else begin
                start_idx = ptr_q - IDX_W'(1);
            end
        end
    end

    // Descending search with wrap: the highest request at or below the start wins,
    // otherwise the highest request overall (the wrapped part of the search).
    always_comb begin
        req_hi    = '0;
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            req_hi[i] = req[i] && (IDX_W'(i) <= start_idx);
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (req_hi[i]) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(i);
            end
            if (req[i]) begin
                found_any = 1'b1;
                idx_any   = IDX_W'(i);
            end
        end
        win_idx = found_hi ? idx_hi : idx_any;
    end

    // Lock holds only while the currently granted source keeps requesting.
    always_comb begin
        held = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (lock && (sel_q == SEL_W'(i + 1)) && req[i]) begin
                held = 1'b1;
            end
        end
    end

    // Next grant, pointer and conflict flag; no stale select survives an idle cycle.
    always_comb begin
        sel_d = '0;
        ptr_d = ptr_q;
        if (held) begin
            sel_d = sel_q;
        end else if (found_any) begin
            sel_d = SEL_W'(win_idx) + SEL_W'(1);
            ptr_d = win_idx;
        end
        valid_d    = (sel_d != '0);
        conflict_d = ($countones(req) > 1);
    end

    // Grant state registers with synchronous reset dropping any grant or lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            ptr_q      <= ptr_d;
        end
    end

    assign sel      = sel_q;
    assign valid    = valid_q;
    assign conflict = conflict_q;

`ifdef BUS_ARBITER_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating conflict counter; clear wins over a simultaneous increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (conflict_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    // Counter absent: output tied off and clear input has no effect.
    assign unused_cnt_clr = cnt_clr;
    assign conflict_cnt   = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (fixed priority and round-robin)
module tb_bus_arbiter;

`ifdef BUS_ARBITER_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [6:0] req;
    logic       lock;
    logic       cnt_clr;

    logic [2:0] fp_sel;
    logic       fp_valid;
    logic       fp_conflict;
    logic [7:0] fp_cnt;

    logic [2:0] rr_sel;
    logic       rr_valid;
    logic       rr_conflict;
    logic [1:0] rr_cnt;

    int n_vec;
    int n_err;

    bus_arbiter #(.N_SRC(7), .SEL_W(3), .RR(0), .CNT_W(8)) dut_fp (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .cnt_clr      (cnt_clr),
        .sel          (fp_sel),
        .valid        (fp_valid),
        .conflict     (fp_conflict),
        .conflict_cnt (fp_cnt)
    );

    bus_arbiter #(.N_SRC(7), .SEL_W(3), .RR(1), .CNT_W(2)) dut_rr (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .cnt_clr      (cnt_clr),
        .sel          (rr_sel),
        .valid        (rr_valid),
        .conflict     (rr_conflict),
        .conflict_cnt (rr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; lock = 1'b0; cnt_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 7'b1111111; lock = 1'b1; cnt_clr = 1'b0;
        tick();
        tick();
        n_vec++;
        if (fp_sel !== 3'd0 || fp_valid !== 1'b0 || fp_conflict !== 1'b0 || fp_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_fp got sel=%0d valid=%0b conflict=%0b cnt=%0d want 0 0 0 0", fp_sel, fp_valid, fp_conflict, fp_cnt);
        end
        n_vec++;
        if (rr_sel !== 3'd0 || rr_valid !== 1'b0 || rr_conflict !== 1'b0 || rr_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL reset_rr got sel=%0d valid=%0b conflict=%0b cnt=%0d want 0 0 0 0", rr_sel, rr_valid, rr_conflict, rr_cnt);
        end
    endtask

    task automatic test_fixed_priority;
        do_reset();
        req = 7'b1001000;
        tick();
        n_vec++;
        if (fp_sel !== 3'd7 || fp_valid !== 1'b1 || fp_conflict !== 1'b1) begin
            n_err++;
            $display("FAIL fixed_two_req got sel=%0d valid=%0b conflict=%0b want 7 1 1", fp_sel, fp_valid, fp_conflict);
        end
        n_vec++;
        if (fp_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            n_err++;
            $display("FAIL fixed_cnt_first got %0d want %0d", fp_cnt, CNT_EN ? 1 : 0);
        end
        req = 7'b0000001;
        tick();
        n_vec++;
        if (fp_sel !== 3'd1 || fp_valid !== 1'b1 || fp_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_single got sel=%0d valid=%0b conflict=%0b want 1 1 0", fp_sel, fp_valid, fp_conflict);
        end
        req = 7'b0000000;
        tick();
        n_vec++;
        if (fp_sel !== 3'd0 || fp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_idle got sel=%0d valid=%0b want 0 0", fp_sel, fp_valid);
        end
        req = 7'b0110010;
        tick();
        n_vec++;
        if (fp_sel !== 3'd6 || fp_conflict !== 1'b1) begin
            n_err++;
            $display("FAIL fixed_mid got sel=%0d conflict=%0b want 6 1", fp_sel, fp_conflict);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_rr [4];
        exp_rr = '{3'd7, 3'd3, 3'd1, 3'd7};
        do_reset();
        req = 7'b1000101;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (rr_sel !== exp_rr[k] || rr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rr_rotate[%0d] got sel=%0d valid=%0b want %0d 1", k, rr_sel, rr_valid, exp_rr[k]);
            end
            n_vec++;
            if (fp_sel !== 3'd7) begin
                n_err++;
                $display("FAIL fp_static[%0d] got sel=%0d want 7", k, fp_sel);
            end
        end
        req = 7'b0000000;
        tick();
        n_vec++;
        if (rr_sel !== 3'd0 || rr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rr_idle got sel=%0d valid=%0b want 0 0", rr_sel, rr_valid);
        end
        req = 7'b1000101;
        tick();
        n_vec++;
        if (rr_sel !== 3'd3) begin
            n_err++;
            $display("FAIL rr_ptr_hold got sel=%0d want 3", rr_sel);
        end
    endtask

    task automatic test_lock;
        do_reset();
        req = 7'b0000100;
        tick();
        n_vec++;
        if (rr_sel !== 3'd3 || fp_sel !== 3'd3) begin
            n_err++;
            $display("FAIL lock_setup got rr=%0d fp=%0d want 3 3", rr_sel, fp_sel);
        end
        lock = 1'b1;
        req  = 7'b1000100;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (rr_sel !== 3'd3 || fp_sel !== 3'd3 || fp_conflict !== 1'b1) begin
                n_err++;
                $display("FAIL lock_hold[%0d] got rr=%0d fp=%0d conflict=%0b want 3 3 1", k, rr_sel, fp_sel, fp_conflict);
            end
        end
        req = 7'b1000000;
        tick();
        n_vec++;
        if (rr_sel !== 3'd7 || fp_sel !== 3'd7) begin
            n_err++;
            $display("FAIL lock_release got rr=%0d fp=%0d want 7 7", rr_sel, fp_sel);
        end
        lock = 1'b0;
        req  = 7'b1000101;
        tick();
        n_vec++;
        if (rr_sel !== 3'd3) begin
            n_err++;
            $display("FAIL lock_rr_after got sel=%0d want 3", rr_sel);
        end
    endtask

    task automatic test_counter;
        logic [1:0] exp_rr [5];
        exp_rr = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        req = 7'b0000011;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (rr_cnt !== (CNT_EN ? exp_rr[k] : 2'd0)) begin
                n_err++;
                $display("FAIL cnt_sat[%0d] got %0d want %0d", k, rr_cnt, CNT_EN ? exp_rr[k] : 2'd0);
            end
            n_vec++;
            if (fp_cnt !== (CNT_EN ? 8'(k + 1) : 8'd0)) begin
                n_err++;
                $display("FAIL cnt_wide[%0d] got %0d want %0d", k, fp_cnt, CNT_EN ? k + 1 : 0);
            end
        end
        cnt_clr = 1'b1;
        tick();
        n_vec++;
        if (rr_cnt !== 2'd0 || fp_cnt !== 8'd0 || rr_conflict !== 1'b1) begin
            n_err++;
            $display("FAIL cnt_clr_prio got rr=%0d fp=%0d conflict=%0b want 0 0 1", rr_cnt, fp_cnt, rr_conflict);
        end
        cnt_clr = 1'b0;
        tick();
        n_vec++;
        if (rr_cnt !== (CNT_EN ? 2'd1 : 2'd0)) begin
            n_err++;
            $display("FAIL cnt_restart got %0d want %0d", rr_cnt, CNT_EN ? 1 : 0);
        end
        req = 7'b0010000;
        tick();
        n_vec++;
        if (rr_cnt !== (CNT_EN ? 2'd1 : 2'd0) || rr_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL cnt_no_conflict got cnt=%0d conflict=%0b want %0d 0", rr_cnt, rr_conflict, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_midlock;
        do_reset();
        req  = 7'b0000100;
        tick();
        tick();
        lock = 1'b1;
        req  = 7'b1111111;
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (rr_sel !== 3'd0 || rr_valid !== 1'b0 || rr_conflict !== 1'b0 || rr_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL reset_midlock got sel=%0d valid=%0b conflict=%0b cnt=%0d want 0 0 0 0", rr_sel, rr_valid, rr_conflict, rr_cnt);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (rr_sel !== 3'd7 || rr_valid !== 1'b1 || rr_conflict !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_grant got sel=%0d valid=%0b conflict=%0b want 7 1 1", rr_sel, rr_valid, rr_conflict);
        end
        lock = 1'b0;
        tick();
        n_vec++;
        if (rr_sel !== 3'd6) begin
            n_err++;
            $display("FAIL reset_next_grant got sel=%0d want 6", rr_sel);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        req     = '0;
        lock    = 1'b0;
        cnt_clr = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_counter();
        test_reset_midlock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_SRC, default 7; number of bus sources; legal range 2..15.
REQ-002 Parameter SEL_W, default 3; select width; SHALL equal ceil(log2(N_SRC+1)).
REQ-003 Parameter RR, default 0; 0 = fixed priority, 1 = round-robin.
REQ-004 Parameter CNT_W, default 8; conflict counter width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req  input  N_SRC  per-source bus drive request; bit i = source i (7-source map: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 M).
REQ-008 lock  input  1  keeps the current grant while the granted source's request stays high.
REQ-009 cnt_clr  input  1  clears the conflict counter.
REQ-010 sel  output  SEL_W  registered bus select; 0 = no source, otherwise granted index + 1.
REQ-011 valid  output  1  registered; high when sel != 0.
REQ-012 conflict  output  1  registered; high when two or more req bits were high in the sampled cycle.
REQ-013 conflict_cnt  output  CNT_W  registered saturating conflict count.

Function
REQ-014 Latency: sel, valid and conflict SHALL reflect the req and lock values sampled at the previous rising edge (1 cycle).
REQ-015 RR=0: the highest-index asserted req bit SHALL win.
REQ-016 RR=1: the search SHALL start at (last granted index - 1) and descend, wrapping from 0 to N_SRC-1; the first asserted bit wins.
REQ-017 RR=1: the last-granted pointer SHALL update only when a grant is issued or changed; it SHALL hold when req = 0.
REQ-018 When req = 0, the next sel SHALL be 0 and valid SHALL be 0; the block SHALL NOT hold a stale select.
REQ-019 When lock=1, valid=1 and req[sel-1]=1, sel SHALL hold regardless of other requests, and the RR pointer SHALL NOT advance.
REQ-020 When lock=1 but the granted req bit is 0, the lock SHALL be ignored and normal arbitration SHALL apply in the same cycle.
REQ-021 conflict SHALL be computed from req alone, whether or not lock is active.
REQ-022 conflict_cnt SHALL increment by 1 each cycle in which the sampled popcount(req) >= 2.
REQ-023 conflict_cnt SHALL saturate at 2^CNT_W - 1 with no wrap.
REQ-024 cnt_clr SHALL set conflict_cnt to 0 on the next edge.
REQ-025 cnt_clr SHALL take priority over a simultaneous increment.
REQ-026 The block SHALL have no latches and no combinational path from any input to any output.

Reset
REQ-027 While rst=1: sel=0, valid=0, conflict=0, conflict_cnt=0.
REQ-028 While rst=1, the RR pointer SHALL be set so that the next search starts at N_SRC-1, identical to fixed priority.
REQ-029 rst SHALL override lock, cnt_clr and req; a grant or lock in progress SHALL be dropped.
REQ-030 On the first edge after rst falls, the block SHALL arbitrate normally.

Configuration
REQ-031 Macro BUS_ARBITER_CONFLICT_CNT_EN.
REQ-032 Macro defined: conflict_cnt and cnt_clr SHALL behave per REQ-022 to REQ-025.
REQ-033 Macro undefined: conflict_cnt SHALL be constant 0, cnt_clr SHALL be ignored, and no counter register SHALL exist.
REQ-034 The port list SHALL be identical in both builds; conflict SHALL be present in both.

Verification
REQ-035 RR=0, N_SRC=7, req=7'b1001000 for 1 cycle -> next cycle sel=3'b111, valid=1, conflict=1, conflict_cnt=1.
REQ-036 RR=0, req=7'b0000001 then req=0 -> sel=3'b001, then sel=3'b000, valid=0.
REQ-037 RR=1, req=7'b1000101 held for 4 cycles -> sel sequence 7, 3, 1, 7 (indices 6, 2, 0, 6).
REQ-038 lock=1 with grant on index 2 (sel=3), then req=7'b1000100 -> sel stays 3; then drop req[2] -> sel=7 the following cycle.
REQ-039 Macro on, CNT_W=2, conflicting req for 5 cycles -> conflict_cnt 1, 2, 3, 3, 3; then cnt_clr and conflict in the same cycle -> 0.
REQ-040 rst=1 asserted mid-lock with req=7'b1111111 -> next cycle all outputs 0; after release under RR=1, first grant is index 6.
